dcdw_array_module: RTL and testbench

//  Parametrised weight-gradient unit for the DQN backprop path. On a trigger it

---
 rtl/dcdw_array_module.sv | 188 ++++++++++++++++++
 tb/tb_dcdw_array_module.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcdw_array_module.sv
// dcdw_array_module: weight-gradient unit for the DQN backprop path.
//
// On a trigger it captures an activation vector a[] and a delta vector delta[].
// It then streams the outer product a[i]*delta[j] over a valid/ready interface.
// The order is j-major: index j*N_IN+i. Each term is scaled by 2^-LR_SHIFT.
// One shared multiplier produces one term per cycle.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-low
//   step        training step; zero blocks triggering
//   controller  phase code; CTRL_TRIG starts a computation
//   a_vec       activations, a[i] = a_vec[i*DW +: DW]
//   delta_vec   deltas, delta[j] = delta_vec[j*DW +: DW]
//   busy        high while the stream is in progress
//   dw_valid    dw_data holds a valid delta-weight
//   dw_ready    consumer accepts when dw_valid && dw_ready
//   dw_data     scaled delta-weight, signed Q(DW-FRAC).FRAC
//   dw_idx_i    i index of dw_data
//   dw_idx_j    j index of dw_data
//   dw_last     marks the final element (N_IN-1, N_OUT-1)
//   done        one-cycle pulse after the last handshake
//
// Build option
//   DCDW_SAT_EN  when defined, the Q-aligned product saturates to the DW signed
//                range; otherwise it wraps around.
module dcdw_array_module #(
    parameter int DW        = 16,
    parameter int FRAC      = 10,
    parameter int N_IN      = 4,
    parameter int N_OUT     = 2,
    parameter int LR_SHIFT  = 5,
    parameter int CTRL_TRIG = 9,
    localparam int IW       = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int JW       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            step,
    input  logic [3:0]            controller,
    input  logic [N_IN*DW-1:0]    a_vec,
    input  logic [N_OUT*DW-1:0]   delta_vec,
    output logic                  busy,
    output logic                  dw_valid,
    input  logic                  dw_ready,
    output logic [DW-1:0]         dw_data,
    output logic [IW-1:0]         dw_idx_i,
    output logic [JW-1:0]         dw_idx_j,
    output logic                  dw_last,
    output logic                  done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [N_IN*DW-1:0]    a_q, a_d;
    logic [N_OUT*DW-1:0]   d_q, d_d;
    logic [IW-1:0]         i_q, i_d;
    logic [JW-1:0]         j_q, j_d;
    logic                  valid_q, valid_d;
    logic [DW-1:0]         data_q, data_d;
    logic [IW-1:0]         oi_q, oi_d;
    logic [JW-1:0]         oj_q, oj_d;
    logic                  last_q, last_d;

    logic                  trig;
    logic                  hs;
    logic                  i_end;
    logic                  j_end;
    logic signed [DW-1:0]  a_sel;
    logic signed [DW-1:0]  d_sel;
    logic signed [2*DW-1:0] p;
    logic signed [DW-1:0]  q;
    logic signed [DW-1:0]  term;

    assign trig  = (step != 4'd0) && (controller == 4'(CTRL_TRIG));
    assign hs    = valid_q && dw_ready;
    assign i_end = (i_q == IW'(N_IN - 1));
    assign j_end = (j_q == JW'(N_OUT - 1));

    // The shared multiplier always works on the term at the issue pointer (i_q, j_q).
    assign a_sel = a_q[i_q*DW +: DW];
    assign d_sel = d_q[j_q*DW +: DW];
    assign p     = a_sel * d_sel;

`ifdef DCDW_SAT_EN
    logic [DW-FRAC:0] upper;
    logic             ovf;

    // p[2*DW-1:FRAC] fits in DW signed bits only when every bit above the
    // Q-aligned slice matches the slice's sign bit.
    assign upper = p[2*DW-1:DW+FRAC-1];
    assign ovf   = !((&upper) || !(|upper));
    assign q     = ovf ? (p[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                       : p[DW+FRAC-1:FRAC];
`else
    assign q     = p[DW+FRAC-1:FRAC];
`endif

    assign term = q >>> LR_SHIFT;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        i_d     = i_q;
        j_d     = j_q;
        valid_d = valid_q;
        data_d  = data_q;
        oi_d    = oi_q;
        oj_d    = oj_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    a_d     = a_vec;
                    d_d     = delta_vec;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (hs && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = StDone;
                end else if (!valid_q || hs) begin
                    // The output register is empty or drains this cycle, so it
                    // takes the next term. After the last term is loaded, this
                    // branch is reached only by the final handshake above.
                    valid_d = 1'b1;
                    data_d  = term;
                    oi_d    = i_q;
                    oj_d    = j_q;
                    last_d  = i_end && j_end;
                    if (i_end) begin
                        i_d = '0;
                        j_d = j_end ? '0 : j_q + 1'b1;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            d_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            oi_q    <= '0;
            oj_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            i_q     <= i_d;
            j_q     <= j_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            oi_q    <= oi_d;
            oj_q    <= oj_d;
            last_q  <= last_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign dw_valid = valid_q;
    assign dw_data  = data_q;
    assign dw_idx_i = oi_q;
    assign dw_idx_j = oj_q;
    assign dw_last  = last_q;

endmodule

// File: tb/tb_dcdw_array_module.sv
// Self-checking bench for dcdw_array_module (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dcdw_array_module;

    localparam int DW    = 16;
    localparam int FRAC  = 10;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int LR    = 5;

    logic              clk;
    logic              rst;
    logic [3:0]        step;
    logic [3:0]        controller;
    logic [N_IN*DW-1:0]  a_vec;
    logic [N_OUT*DW-1:0] delta_vec;
    logic              busy;
    logic              dw_valid;
    logic              dw_ready;
    logic [DW-1:0]     dw_data;
    logic [1:0]        dw_idx_i;
    logic [0:0]        dw_idx_j;
    logic              dw_last;
    logic              done;

    typedef struct packed {
        logic [0:0]  j;
        logic [1:0]  i;
        logic [15:0] d;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    dcdw_array_module dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .controller (controller),
        .a_vec      (a_vec),
        .delta_vec  (delta_vec),
        .busy       (busy),
        .dw_valid   (dw_valid),
        .dw_ready   (dw_ready),
        .dw_data    (dw_data),
        .dw_idx_i   (dw_idx_i),
        .dw_idx_j   (dw_idx_j),
        .dw_last    (dw_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: integer product, floor shift to Q alignment, optional clamp,
    // then the learning-rate shift.
    function automatic logic [15:0] ref_dw(input logic signed [15:0] a,
                                           input logic signed [15:0] d);
        longint      s;
        logic [15:0] q;
        s = (longint'(a) * longint'(d)) >>> FRAC;
`ifdef DCDW_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        q = s[15:0];
        return 16'($signed(q) >>> LR);
    endfunction

    task automatic push_all(input logic [63:0] av, input logic [31:0] dv,
                            input bit use_const, input logic [15:0] cval);
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                exp_t e;
                e.j    = j[0:0];
                e.i    = i[1:0];
                e.d    = use_const ? cval : ref_dw(av[i*16 +: 16], dv[j*16 +: 16]);
                e.last = (i == N_IN - 1) && (j == N_OUT - 1);
                sb.push_back(e);
            end
        end
    endtask

    // Called on a falling edge. Captures on the next rising edge, then scrambles
    // the input vectors so that a late capture would be visible.
    task automatic trigger(input logic [63:0] av, input logic [31:0] dv, input bit hold);
        a_vec      = av;
        delta_vec  = dv;
        step       = 4'd1;
        controller = 4'd9;
        @(negedge clk);
        if (!hold) controller = 4'd0;
        a_vec     = ~av;
        delta_vec = ~dv;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL trig_busy: busy=%b expected 1", busy);
        end
    endtask

    task automatic pop_check(input string name);
        logic [19:0] obs;
        exp_t        e;
        obs = {dw_idx_j, dw_idx_i, dw_data, dw_last};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_extra: unexpected term {j,i,data,last}=%h", name, obs);
        end else begin
            e = sb.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL %s_term: {j,i,data,last}=%h expected %h", name, obs, e);
            end
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1 repeating, 2: random ready.
    task automatic run_stream(input string name, input int mode, input bit hold);
        bit          got_last = 0;
        bit          prev_stall = 0;
        bit          r;
        logic [19:0] held = '0;
        logic [19:0] cur;
        int          cyc = 0;
        while (!got_last && cyc < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            dw_ready = r;
            cur = {dw_idx_j, dw_idx_i, dw_data, dw_last};
            if (prev_stall) begin
                checks++;
                if (dw_valid !== 1'b1 || cur !== held) begin
                    errors++;
                    $display("FAIL %s_stall_hold: valid=%b term=%h expected 1 %h",
                             name, dw_valid, cur, held);
                end
            end
            if (dw_valid === 1'b1 && r) begin
                pop_check(name);
                if (dw_last === 1'b1) got_last = 1;
            end
            prev_stall = (dw_valid === 1'b1) && !r;
            held = cur;
            @(negedge clk);
            cyc++;
        end
        dw_ready = 1'b0;
        checks++;
        if (!got_last) begin
            errors++;
            $display("FAIL %s_timeout: last term not seen within %0d cycles", name, cyc);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dw_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b busy=%b valid=%b expected 1 0 0",
                     name, done, busy, dw_valid);
        end
        @(negedge clk);
        if (hold) controller = 4'd0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b expected 0 0", name, done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dw_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b valid=%b left=%0d expected 0 0 0",
                     name, busy, dw_valid, sb.size());
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({busy, dw_valid, dw_data, dw_idx_i, dw_idx_j, dw_last, done} !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b valid=%b data=%h i=%0d j=%0d last=%b done=%b, expected all 0",
                     name, busy, dw_valid, dw_data, dw_idx_i, dw_idx_j, dw_last, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        check_quiet("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");
    endtask

    task automatic test_step_gate;
        step       = 4'd0;
        controller = 4'd9;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || dw_valid !== 1'b0) begin
                errors++;
                $display("FAIL step_gate: busy=%b valid=%b expected 0 0", busy, dw_valid);
            end
        end
        controller = 4'd0;
        push_all(64'h0800_F800_0400_FC00, 32'h2000_E000, 0, 16'h0);
        trigger(64'h0800_F800_0400_FC00, 32'h2000_E000, 0);
        run_stream("step_run", 0, 0);
    endtask

    task automatic test_positive;
        push_all({4{16'h1000}}, {2{16'h1000}}, 1, 16'h0200);
        trigger({4{16'h1000}}, {2{16'h1000}}, 0);
        run_stream("pos", 0, 0);
    endtask

    task automatic test_negative;
        push_all({4{16'hF000}}, {2{16'h1000}}, 1, 16'hFE00);
        trigger({4{16'hF000}}, {2{16'h1000}}, 0);
        run_stream("neg", 0, 0);
    endtask

    task automatic test_overflow;
`ifdef DCDW_SAT_EN
        push_all({4{16'h7C00}}, {2{16'h7C00}}, 1, 16'h03FF);
`else
        push_all({4{16'h7C00}}, {2{16'h7C00}}, 1, 16'h0020);
`endif
        trigger({4{16'h7C00}}, {2{16'h7C00}}, 0);
        run_stream("ovf", 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [63:0] av;
        logic [31:0] dv;
        for (int n = 0; n < 3; n++) begin
            av = {$urandom, $urandom};
            dv = $urandom;
            push_all(av, dv, 0, 16'h0);
            trigger(av, dv, (n == 0));
            run_stream("bp", (n == 0) ? 1 : 2, (n == 0));
        end
    endtask

    task automatic test_abort;
        logic [63:0] av;
        logic [31:0] dv;
        int          got = 0;
        int          cyc = 0;
        av = 64'h1234_0567_F9AB_0CDE;
        dv = 32'h0A00_F300;
        push_all(av, dv, 0, 16'h0);
        trigger(av, dv, 0);
        while (got < 3 && cyc < 50) begin
            dw_ready = 1'b1;
            if (dw_valid === 1'b1) begin
                pop_check("abort_pre");
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (got < 3) begin
            errors++;
            $display("FAIL abort_pre_timeout: got %0d terms expected 3", got);
        end
        rst = 1'b0;
        #1;
        check_quiet("abort_reset");
        @(negedge clk);
        rst = 1'b1;
        dw_ready = 1'b1;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_quiet("abort_quiet");
        end
        dw_ready = 1'b0;
        av = 64'h0200_FE00_0100_0300;
        dv = 32'h1800_F000;
        push_all(av, dv, 0, 16'h0);
        trigger(av, dv, 0);
        run_stream("abort_restart", 0, 0);
    endtask

    initial begin
        rst        = 1'b0;
        step       = 4'd0;
        controller = 4'd0;
        a_vec      = '0;
        delta_vec  = '0;
        dw_ready   = 1'b0;
        @(negedge clk);
        test_reset;
        test_step_gate;
        test_positive;
        test_negative;
        test_overflow;
        test_back_to_back;
        test_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
